// File: rtl/fb_arbiter.sv
// fb_arbiter: single-port frame-buffer arbiter between the PPU pixel writer and
// the VGA scan-out reader. VGA reads own the RAM port whenever requested; PPU
// writes are parked in a small FIFO and drained on cycles with no read.
//
// Optional feature macro: FB_WBUF_FWD_EN -- when defined, reads that hit a
// buffered write return the newest buffered pixel instead of stale RAM data.
//
// Ports:
//   pix_clk, reset_n            clock, asynchronous active-low reset
//   rd_req, rd_x, rd_y          VGA read request and pixel pointer
//   rd_data, rd_valid           read result, one cycle after rd_req
//   wr_valid, wr_ready          PPU write handshake
//   wr_x, wr_y, wr_rgb          PPU write pixel
//   mem_addr, mem_we, mem_wdata RAM port (combinational)
//   mem_rdata                   RAM read data, 1-cycle latency
//   wbuf_level                  write-buffer occupancy
//   drop_cnt                    saturating count of writes with y >= 240
module fb_arbiter #(
    parameter int unsigned WBUF_DEPTH = 4
) (
    input  logic                          pix_clk,
    input  logic                          reset_n,
    input  logic                          rd_req,
    input  logic [7:0]                    rd_x,
    input  logic [7:0]                    rd_y,
    output logic [8:0]                    rd_data,
    output logic                          rd_valid,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    input  logic [7:0]                    wr_x,
    input  logic [7:0]                    wr_y,
    input  logic [8:0]                    wr_rgb,
    output logic [15:0]                   mem_addr,
    output logic                          mem_we,
    output logic [8:0]                    mem_wdata,
    input  logic [8:0]                    mem_rdata,
    output logic [$clog2(WBUF_DEPTH):0]   wbuf_level,
    output logic [15:0]                   drop_cnt
);

    localparam int unsigned PW = $clog2(WBUF_DEPTH);

    logic [15:0] fifo_addr [WBUF_DEPTH];
    logic [8:0]  fifo_rgb  [WBUF_DEPTH];
    logic [PW-1:0] head_q, tail_q;
    logic [PW:0]   level_q;
    logic [15:0]   drop_q;
    logic          rd_valid_q;

    logic accept, push, pop, row_ok;

    assign wr_ready = (level_q < (PW+1)'(WBUF_DEPTH));
    assign row_ok   = (wr_y < 8'd240);
    assign accept   = wr_valid && wr_ready;
    assign push     = accept && row_ok;
    // Reads always win the port; the head only drains on read-free cycles.
    assign pop      = !rd_req && (level_q != '0);

    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        if (rd_req) begin
            mem_addr = {rd_y, rd_x};
        end else if (level_q != '0) begin
            mem_addr  = fifo_addr[head_q];
            mem_wdata = fifo_rgb[head_q];
            mem_we    = 1'b1;
        end
    end

    // Storage needs no reset: only entries covered by level_q are ever read.
    always_ff @(posedge pix_clk) begin
        if (push) begin
            fifo_addr[tail_q] <= {wr_y, wr_x};
            fifo_rgb[tail_q]  <= wr_rgb;
        end
    end

    always_ff @(posedge pix_clk or negedge reset_n) begin
        if (!reset_n) begin
            head_q     <= '0;
            tail_q     <= '0;
            level_q    <= '0;
            drop_q     <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_req;
            // Pointers wrap naturally since the depth is a power of two.
            if (push) tail_q <= tail_q + 1'b1;
            if (pop)  head_q <= head_q + 1'b1;
            case ({push, pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: ;
            endcase
            if (accept && !row_ok && (drop_q != 16'hFFFF)) drop_q <= drop_q + 1'b1;
        end
    end

`ifdef FB_WBUF_FWD_EN
    logic       fwd_hit_d, fwd_hit_q;
    logic [8:0] fwd_rgb_d, fwd_rgb_q;

    // Walk oldest to newest so the newest matching entry wins.
    always_comb begin
        fwd_hit_d = 1'b0;
        fwd_rgb_d = '0;
        for (int unsigned i = 0; i < WBUF_DEPTH; i++) begin
            if (((PW+1)'(i) < level_q) &&
                (fifo_addr[head_q + PW'(i)] == {rd_y, rd_x})) begin
                fwd_hit_d = 1'b1;
                fwd_rgb_d = fifo_rgb[head_q + PW'(i)];
            end
        end
    end

    always_ff @(posedge pix_clk or negedge reset_n) begin
        if (!reset_n) begin
            fwd_hit_q <= 1'b0;
            fwd_rgb_q <= '0;
        end else begin
            fwd_hit_q <= rd_req && fwd_hit_d;
            fwd_rgb_q <= fwd_rgb_d;
        end
    end

    assign rd_data = rd_valid_q ? (fwd_hit_q ? fwd_rgb_q : mem_rdata) : '0;
`else
    assign rd_data = rd_valid_q ? mem_rdata : '0;
`endif

    assign rd_valid   = rd_valid_q;
    assign wbuf_level = level_q;
    assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_fb_arbiter.sv
// Testbench for fb_arbiter: directed scenarios plus randomized traffic checked
// against a queue-based model of the write buffer and a shadow frame buffer.
module tb_fb_arbiter;

    localparam int unsigned D = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        rd_req = 1'b0;
    logic [7:0]  rd_x = '0, rd_y = '0;
    logic [8:0]  rd_data;
    logic        rd_valid;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [7:0]  wr_x = '0, wr_y = '0;
    logic [8:0]  wr_rgb = '0;
    logic [15:0] mem_addr;
    logic        mem_we;
    logic [8:0]  mem_wdata;
    bit   [8:0]  mem_rdata;
    logic [2:0]  wbuf_level;
    logic [15:0] drop_cnt;

    always #5 clk = ~clk;

    fb_arbiter #(.WBUF_DEPTH(D)) dut (
        .pix_clk(clk), .reset_n(reset_n),
        .rd_req(rd_req), .rd_x(rd_x), .rd_y(rd_y),
        .rd_data(rd_data), .rd_valid(rd_valid),
        .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_x(wr_x), .wr_y(wr_y), .wr_rgb(wr_rgb),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .wbuf_level(wbuf_level), .drop_cnt(drop_cnt)
    );

    // Physical frame-buffer RAM, 1-cycle read latency.
    bit [8:0] ram [65536];
    always @(posedge clk) begin
        if (mem_we === 1'b1) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    // Reference model: pending writes as a queue, expected RAM contents.
    bit [8:0]    ram_m [65536];
    bit [15:0]   q_addr[$];
    bit [8:0]    q_rgb[$];
    int unsigned drop_m = 0;
    bit          e_rd_valid = 1'b0;
    bit [8:0]    e_rd_data = '0;
    int          total = 0;
    int          bad = 0;

    task automatic drive(input bit rq, input bit [7:0] rx, input bit [7:0] ry, input bit wv,
                         input bit [7:0] wx, input bit [7:0] wy, input bit [8:0] rgb);
        @(negedge clk);
        rd_req = rq; rd_x = rx; rd_y = ry;
        wr_valid = wv; wr_x = wx; wr_y = wy; wr_rgb = rgb;
        #1;
    endtask

    // Advance the model across one rising edge using the driven inputs.
    task automatic tick();
        bit [15:0] ra;
        bit        acc;
        @(posedge clk);
        ra  = {rd_y, rd_x};
        acc = wr_valid && (q_addr.size() < D);
        e_rd_valid = rd_req;
        if (rd_req) begin
            e_rd_data = ram_m[ra];
`ifdef FB_WBUF_FWD_EN
            foreach (q_addr[i]) if (q_addr[i] == ra) e_rd_data = q_rgb[i];
`endif
        end else if (q_addr.size() > 0) begin
            ram_m[q_addr[0]] = q_rgb[0];
            void'(q_addr.pop_front());
            void'(q_rgb.pop_front());
        end
        if (acc) begin
            if (wr_y >= 8'd240) begin
                if (drop_m < 65535) drop_m++;
            end else begin
                q_addr.push_back({wr_y, wr_x});
                q_rgb.push_back(wr_rgb);
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", wr_ready); end
        total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL reset_we got=%b exp=0", mem_we); end
        total++; if (mem_addr !== 16'h0) begin bad++; $display("FAIL reset_addr got=%h exp=0", mem_addr); end
        total++; if (wbuf_level !== 3'd0) begin bad++; $display("FAIL reset_level got=%0d exp=0", wbuf_level); end
        total++; if (drop_cnt !== 16'd0) begin bad++; $display("FAIL reset_drop got=%0d exp=0", drop_cnt); end
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL reset_rd_valid got=%b exp=0", rd_valid); end
        total++; if (rd_data !== 9'h0) begin bad++; $display("FAIL reset_rd_data got=%h exp=0", rd_data); end
        tick();
    endtask

    task automatic test_single();
        drive(0, 0, 0, 1, 8'd5, 8'd3, 9'h1A5);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        total++; if (mem_we !== 1'b1) begin bad++; $display("FAIL single_we got=%b exp=1", mem_we); end
        total++; if (mem_addr !== 16'h0305) begin bad++; $display("FAIL single_addr got=%h exp=0305", mem_addr); end
        total++; if (mem_wdata !== 9'h1A5) begin bad++; $display("FAIL single_wdata got=%h exp=1a5", mem_wdata); end
        tick();
        drive(1, 8'd5, 8'd3, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        total++; if (rd_valid !== 1'b1) begin bad++; $display("FAIL single_rd_valid got=%b exp=1", rd_valid); end
        total++; if (rd_data !== 9'h1A5) begin bad++; $display("FAIL single_rd_data got=%h exp=1a5", rd_data); end
        tick();
    endtask

    task automatic test_backpressure();
        int k = 0;
        int drained = 0;
        bit acc;
        for (int c = 0; c < 20; c++) begin
            drive(1, 8'd0, 8'd0, k < 6, 8'(k), 8'd50, 9'(100 + k));
            total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL bp_we_during_read cyc=%0d got=%b exp=0", c, mem_we); end
            acc = (k < 6) && (q_addr.size() < D);
            tick();
            if (acc) k++;
        end
        drive(1, 8'd0, 8'd0, 1, 8'(k), 8'd50, 9'(100 + k));
        total++; if (wbuf_level !== 3'd4) begin bad++; $display("FAIL bp_level got=%0d exp=4", wbuf_level); end
        total++; if (wr_ready !== 1'b0) begin bad++; $display("FAIL bp_ready got=%b exp=0", wr_ready); end
        total++; if (k != 4) begin bad++; $display("FAIL bp_accepts got=%0d exp=4", k); end
        for (int c = 0; c < 30 && drained < 6; c++) begin
            drive(0, 8'd0, 8'd0, k < 6, 8'(k), 8'd50, 9'(100 + k));
            if (c < 4) begin
                total++; if (mem_we !== 1'b1) begin bad++; $display("FAIL bp_drain_we cyc=%0d got=%b exp=1", c, mem_we); end
            end
            if (mem_we === 1'b1) begin
                total++;
                if (mem_addr !== {8'd50, 8'(drained)} || mem_wdata !== 9'(100 + drained)) begin
                    bad++;
                    $display("FAIL bp_drain_order got=%h/%h exp=%h/%h", mem_addr, mem_wdata,
                             {8'd50, 8'(drained)}, 9'(100 + drained));
                end
                drained++;
            end
            acc = (k < 6) && (q_addr.size() < D);
            tick();
            if (acc) k++;
        end
        total++; if (drained != 6 || k != 6) begin bad++; $display("FAIL bp_complete got=%0d/%0d exp=6/6", drained, k); end
        drive(0, 0, 0, 0, 0, 0, 0);
        tick();
    endtask

    task automatic test_invalid_row();
        drive(0, 0, 0, 1, 8'd7, 8'd240, 9'h1FF);
        total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL inv_ready got=%b exp=1", wr_ready); end
        tick();
        drive(0, 0, 0, 1, 8'd7, 8'd255, 9'h1FF);
        total++; if (wbuf_level !== 3'd0 || mem_we !== 1'b0) begin bad++; $display("FAIL inv_first got=%0d/%b exp=0/0", wbuf_level, mem_we); end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        total++; if (wbuf_level !== 3'd0 || mem_we !== 1'b0) begin bad++; $display("FAIL inv_second got=%0d/%b exp=0/0", wbuf_level, mem_we); end
        total++; if (drop_cnt !== 16'd2) begin bad++; $display("FAIL inv_drop got=%0d exp=2", drop_cnt); end
        tick();
    endtask

    task automatic test_forward();
        bit [8:0] exp;
        drive(0, 0, 0, 1, 8'd10, 8'd10, 9'h0AA);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        tick();
        drive(1, 8'd0, 8'd0, 1, 8'd10, 8'd10, 9'h011);
        tick();
        drive(1, 8'd0, 8'd0, 1, 8'd10, 8'd10, 9'h022);
        tick();
        drive(1, 8'd10, 8'd10, 0, 0, 0, 0);
        tick();
        drive(1, 8'd0, 8'd0, 0, 0, 0, 0);
`ifdef FB_WBUF_FWD_EN
        exp = 9'h022;
`else
        exp = 9'h0AA;
`endif
        total++; if (rd_valid !== 1'b1 || rd_data !== exp) begin bad++; $display("FAIL fwd_read got=%b/%h exp=1/%h", rd_valid, rd_data, exp); end
        tick();
        repeat (3) begin drive(0, 0, 0, 0, 0, 0, 0); tick(); end
        drive(1, 8'd10, 8'd10, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        total++; if (rd_data !== 9'h022) begin bad++; $display("FAIL fwd_after_drain got=%h exp=022", rd_data); end
        tick();
    endtask

    task automatic test_reset_traffic();
        drive(1, 0, 0, 1, 8'd20, 8'd1, 9'h155); tick();
        drive(1, 0, 0, 1, 8'd21, 8'd1, 9'h0F0); tick();
        drive(1, 0, 0, 1, 8'd22, 8'd1, 9'h1E1); tick();
        drive(1, 0, 0, 0, 0, 0, 0);
        total++; if (wbuf_level !== 3'd3) begin bad++; $display("FAIL rst_pre_level got=%0d exp=3", wbuf_level); end
        rd_req = 1'b0;
        #1;
        reset_n = 1'b0;
        #1;
        total++; if (wbuf_level !== 3'd0) begin bad++; $display("FAIL rst_level got=%0d exp=0", wbuf_level); end
        total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL rst_we got=%b exp=0", mem_we); end
        q_addr.delete(); q_rgb.delete();
        drop_m = 0; e_rd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1, 8'(20 + i), 8'd1, 0, 0, 0, 0);
            tick();
            drive(0, 0, 0, 0, 0, 0, 0);
            total++; if (rd_valid !== 1'b1 || rd_data !== 9'h000) begin bad++; $display("FAIL rst_ram_clean x=%0d got=%b/%h exp=1/000", 20 + i, rd_valid, rd_data); end
            tick();
        end
    endtask

    task automatic test_random();
        bit        rq, wv, x_we;
        bit [7:0]  wy;
        bit [15:0] x_addr;
        for (int c = 0; c < 400; c++) begin
            rq = ($urandom_range(0, 9) < 5);
            wv = ($urandom_range(0, 3) != 0);
            wy = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(240, 255)) : 8'($urandom_range(0, 3));
            drive(rq, 8'($urandom_range(0, 3)), 8'($urandom_range(0, 3)), wv,
                  8'($urandom_range(0, 3)), wy, 9'($urandom));
            x_we   = !rq && (q_addr.size() > 0);
            x_addr = rq ? {rd_y, rd_x} : (q_addr.size() > 0 ? q_addr[0] : 16'h0);
            total++; if (wr_ready !== (q_addr.size() < D)) begin bad++; $display("FAIL rnd_ready cyc=%0d got=%b", c, wr_ready); end
            total++; if (wbuf_level !== 3'(q_addr.size())) begin bad++; $display("FAIL rnd_level cyc=%0d got=%0d exp=%0d", c, wbuf_level, q_addr.size()); end
            total++; if (mem_we !== x_we) begin bad++; $display("FAIL rnd_we cyc=%0d got=%b exp=%b", c, mem_we, x_we); end
            total++; if (mem_addr !== x_addr) begin bad++; $display("FAIL rnd_addr cyc=%0d got=%h exp=%h", c, mem_addr, x_addr); end
            if (x_we) begin
                total++; if (mem_wdata !== q_rgb[0]) begin bad++; $display("FAIL rnd_wdata cyc=%0d got=%h exp=%h", c, mem_wdata, q_rgb[0]); end
            end
            total++; if (rd_valid !== e_rd_valid) begin bad++; $display("FAIL rnd_rd_valid cyc=%0d got=%b exp=%b", c, rd_valid, e_rd_valid); end
            if (e_rd_valid) begin
                total++; if (rd_data !== e_rd_data) begin bad++; $display("FAIL rnd_rd_data cyc=%0d got=%h exp=%h", c, rd_data, e_rd_data); end
            end
            total++; if (drop_cnt !== 16'(drop_m)) begin bad++; $display("FAIL rnd_drop cyc=%0d got=%0d exp=%0d", c, drop_cnt, drop_m); end
            tick();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_invalid_row();
        test_forward();
        test_reset_traffic();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
